// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for an 8-digit common-anode seven-segment display.
// Each scan_tick advances one digit slot. Every slot starts with an all-off
// blanking gap of BLANK_CYCLES clocks, then drives the digit. Display contents
// are held in a shadow register that is reloaded only at frame boundaries.
// Optional feature macro: SEG_LZB_EN (leading-zero blanking). When it is
// undefined, only the enable mask controls which digits are visible.
//
// Load handshake: the requester raises load_req and holds it, together with
// stable data_in/dp_in/en_in, until it sees load_ack. load_ack is a one-cycle
// pulse, registered, and marks the boundary at which the inputs were captured
// into the shadow. A load_req that is low at a boundary leaves the shadow as is.
module seg_scan_ctrl #(
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        scan_tick,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    input  logic        load_req,
    output logic        load_ack,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // Counter reload value: the gap lasts BLANK_CYCLES clocks, counting down to zero.
    localparam bit          BLANK_ZERO = (BLANK_CYCLES == 0);
    localparam logic [15:0] BLANK_LOAD = BLANK_ZERO ? 16'd0 : 16'(BLANK_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  digit_idx, idx_nxt;
    logic [15:0] blank_cnt, cnt_nxt;

    logic [31:0] sh_data, sh_data_nxt;
    logic [7:0]  sh_dp, sh_dp_nxt;
    logic [7:0]  sh_en, sh_en_nxt;

    logic        boundary;
    logic        start_slot;
    logic        load_take;
    logic [7:0]  lzb_ok;
    logic        lzb_acc;
    logic        visible;
    logic [3:0]  nibble;

    logic [7:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    // Active-low segment pattern for one hex nibble, bit order g..a.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next-state logic: slot sequencing, blank counter, frame boundary and shadow load.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = digit_idx;
        cnt_nxt    = blank_cnt;
        boundary   = 1'b0;
        start_slot = 1'b0;

        case (state)
            S_WAIT: begin
                if (scan_tick) begin
                    boundary   = 1'b1;
                    start_slot = 1'b1;
                    idx_nxt    = 3'd0;
                end
            end
            S_BLANK: begin
                // Ticks arriving during the gap are intentionally ignored.
                if (blank_cnt == 16'd0) begin
                    state_nxt = S_DRIVE;
                end else begin
                    cnt_nxt = blank_cnt - 16'd1;
                end
            end
            S_DRIVE: begin
                if (scan_tick) begin
                    start_slot = 1'b1;
                    idx_nxt    = digit_idx + 3'd1;
                    boundary   = (digit_idx == 3'd7);
                end
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase

        if (start_slot) begin
            if (BLANK_ZERO) begin
                state_nxt = S_DRIVE;
            end else begin
                state_nxt = S_BLANK;
                cnt_nxt   = BLANK_LOAD;
            end
        end

        load_take   = boundary & load_req;
        sh_data_nxt = load_take ? data_in : sh_data;
        sh_dp_nxt   = load_take ? dp_in   : sh_dp;
        sh_en_nxt   = load_take ? en_in   : sh_en;
    end

    // Visibility mask from leading-zero blanking; digit 0 is governed by en only.
    always_comb begin
        lzb_ok  = 8'hFF;
        lzb_acc = 1'b0;
`ifdef SEG_LZB_EN
        for (int k = 7; k >= 0; k--) begin
            lzb_acc   = lzb_acc | (|sh_data_nxt[4*k +: 4]);
            lzb_ok[k] = lzb_acc;
        end
        lzb_ok[0] = 1'b1;
`else
        lzb_acc = 1'b0;
`endif
    end

    // Output values for the next cycle, derived from next state and next shadow.
    always_comb begin
        nibble  = sh_data_nxt[{idx_nxt, 2'b00} +: 4];
        visible = (state_nxt == S_DRIVE) && sh_en_nxt[idx_nxt] && lzb_ok[idx_nxt];
        an_nxt  = 8'hFF;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (visible) begin
            an_nxt  = ~(8'b0000_0001 << idx_nxt);
            seg_nxt = hex7(nibble);
            dp_nxt  = ~sh_dp_nxt[idx_nxt];
        end
    end

    // State, shadow and registered outputs; async reset clears everything.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= S_WAIT;
            digit_idx   <= 3'd0;
            blank_cnt   <= 16'd0;
            sh_data     <= 32'd0;
            sh_dp       <= 8'd0;
            sh_en       <= 8'd0;
            an          <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            digit_idx   <= idx_nxt;
            blank_cnt   <= cnt_nxt;
            sh_data     <= sh_data_nxt;
            sh_dp       <= sh_dp_nxt;
            sh_en       <= sh_en_nxt;
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            load_ack    <= load_take;
            frame_start <= boundary;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: directed scan frames with hand-computed
// digit patterns; a monitor compares each event against expectation queues.
module tb_seg_scan_ctrl;

    localparam int BLANK = 4;
    localparam int SPACE = 10;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        scan_tick;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  en_in;
    logic        load_req;
    logic        load_ack;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected digit events: {cycle, an, seg, dp}; pulse events: cycle only.
    logic [47:0] exp_q[$];
    logic [31:0] ack_q[$];
    logic [31:0] fs_q[$];
    logic [7:0]  prev_an = 8'hFF;

    seg_scan_ctrl #(.BLANK_CYCLES(BLANK)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .scan_tick   (scan_tick),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .load_req    (load_req),
        .load_ack    (load_ack),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start),
        .state_dbg   (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_off(input string name);
        check({name, ".an"}, 64'(an), 64'(8'hFF));
        check({name, ".seg"}, 64'(seg), 64'(7'h7F));
        check({name, ".dp"}, 64'(dp), 64'(1'b1));
    endtask

    // Monitor: pops an expectation whenever the DUT presents a pulse or starts a digit.
    always @(negedge clk_in) begin
        if (reset) begin
            prev_an = 8'hFF;
        end else begin
            if (load_ack) begin
                if (ack_q.size() == 0) check("load_ack_unexpected", 64'(cyc), 64'hFFFF_FFFF);
                else check("load_ack_cycle", 64'(cyc), 64'(ack_q.pop_front()));
            end
            if (frame_start) begin
                if (fs_q.size() == 0) check("frame_start_unexpected", 64'(cyc), 64'hFFFF_FFFF);
                else check("frame_start_cycle", 64'(cyc), 64'(fs_q.pop_front()));
            end
            if (an != 8'hFF && prev_an == 8'hFF) begin
                if (exp_q.size() == 0) check("digit_unexpected", {32'(cyc), an, 1'b0, seg, 7'd0, dp}, 64'hFFFF_FFFF);
                else check("digit {cyc,an,seg,dp}", 64'({32'(cyc), an, seg, dp}), 64'(exp_q.pop_front()));
            end
            prev_an = an;
        end
    end

    // Driver: one scan tick plus the expectations it implies, then the slot gap.
    task automatic do_tick(input bit disp, input logic [7:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input bit e_fs, input bit e_ack);
        int te;
        @(negedge clk_in);
        te = cyc + 1;
        scan_tick = 1'b1;
        if (e_fs)  fs_q.push_back(32'(te));
        if (e_ack) ack_q.push_back(32'(te));
        if (disp)  exp_q.push_back({32'(te + BLANK), e_an, e_seg, e_dp});
        @(negedge clk_in);
        scan_tick = 1'b0;
        if (e_ack) load_req = 1'b0;
        for (int i = 1; i < SPACE; i++) begin
            if (!disp && cyc == te + BLANK) check_off("dark_slot");
            @(negedge clk_in);
        end
    endtask

    task automatic request(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
        data_in  = d;
        dp_in    = p;
        en_in    = e;
        load_req = 1'b1;
    endtask

    logic [7:0] an_k;

    initial begin
        reset     = 1'b1;
        scan_tick = 1'b0;
        data_in   = 32'd0;
        dp_in     = 8'd0;
        en_in     = 8'd0;
        load_req  = 1'b0;

        // Reset state
        #12;
        check_off("reset");
        check("reset.load_ack", 64'(load_ack), 64'(1'b0));
        check("reset.frame_start", 64'(frame_start), 64'(1'b0));
        check("reset.state", 64'(state_dbg), 64'(2'd0));
        @(negedge clk_in);
        reset = 1'b0;
        repeat (20) @(negedge clk_in);
        check_off("idle");
        check("idle.load_ack", 64'(load_ack), 64'(1'b0));

        // Load and scan: first frame from 89ABCDEF, dp on digit 0
        request(32'h89AB_CDEF, 8'h01, 8'hFF);
        do_tick(1, 8'hFE, 7'b0001110, 1'b0, 1, 1);
        do_tick(1, 8'hFD, 7'b0000110, 1'b1, 0, 0);
        do_tick(1, 8'hFB, 7'b0100001, 1'b1, 0, 0);
        do_tick(1, 8'hF7, 7'b1000110, 1'b1, 0, 0);
        do_tick(1, 8'hEF, 7'b0000011, 1'b1, 0, 0);
        do_tick(1, 8'hDF, 7'b0001000, 1'b1, 0, 0);
        do_tick(1, 8'hBF, 7'b0010000, 1'b1, 0, 0);
        do_tick(1, 8'h7F, 7'b0000000, 1'b1, 0, 0);
        // Ninth tick wraps: frame_start, no load, shadow unchanged
        do_tick(1, 8'hFE, 7'b0001110, 1'b0, 1, 0);
        do_tick(1, 8'hFD, 7'b0000110, 1'b1, 0, 0);
        do_tick(1, 8'hFB, 7'b0100001, 1'b1, 0, 0);
        do_tick(1, 8'hF7, 7'b1000110, 1'b1, 0, 0);

        // Mid-frame load while digit 3 is driven: old values until the wrap
        request(32'h0123_4567, 8'h00, 8'hFF);
        do_tick(1, 8'hEF, 7'b0000011, 1'b1, 0, 0);
        do_tick(1, 8'hDF, 7'b0001000, 1'b1, 0, 0);
        do_tick(1, 8'hBF, 7'b0010000, 1'b1, 0, 0);
        do_tick(1, 8'h7F, 7'b0000000, 1'b1, 0, 0);
        do_tick(1, 8'hFE, 7'b1111000, 1'b1, 1, 1);
        do_tick(1, 8'hFD, 7'b0000010, 1'b1, 0, 0);
        do_tick(1, 8'hFB, 7'b0010010, 1'b1, 0, 0);
        do_tick(1, 8'hF7, 7'b0011001, 1'b1, 0, 0);
        do_tick(1, 8'hEF, 7'b0110000, 1'b1, 0, 0);
        do_tick(1, 8'hDF, 7'b0100100, 1'b1, 0, 0);
        do_tick(1, 8'hBF, 7'b1111001, 1'b1, 0, 0);
        do_tick(1, 8'h7F, 7'b1000000, 1'b1, 0, 0);

        // Enable mask 0F: slots 4..7 stay dark
        request(32'h0123_4567, 8'h00, 8'h0F);
        do_tick(1, 8'hFE, 7'b1111000, 1'b1, 1, 1);
        do_tick(1, 8'hFD, 7'b0000010, 1'b1, 0, 0);
        do_tick(1, 8'hFB, 7'b0010010, 1'b1, 0, 0);
        do_tick(1, 8'hF7, 7'b0011001, 1'b1, 0, 0);
        do_tick(0, 8'hFF, 7'h7F, 1'b1, 0, 0);

        // Reset during the blanking gap of digit 5
        @(negedge clk_in);
        scan_tick = 1'b1;
        @(negedge clk_in);
        scan_tick = 1'b0;
        check("blank5.state", 64'(state_dbg), 64'(2'd1));
        #2 reset = 1'b1;
        #1;
        check_off("mid_reset");
        check("mid_reset.state", 64'(state_dbg), 64'(2'd0));
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);

        // Restart at digit 0 with a cleared shadow: nothing lit
        do_tick(0, 8'hFF, 7'h7F, 1'b1, 1, 0);
        for (int k = 1; k < 8; k++) do_tick(0, 8'hFF, 7'h7F, 1'b1, 0, 0);

        // Value 0x120: leading zeros dark only with blanking enabled
        request(32'h0000_0120, 8'h00, 8'hFF);
        do_tick(1, 8'hFE, 7'b1000000, 1'b1, 1, 1);
        do_tick(1, 8'hFD, 7'b0100100, 1'b1, 0, 0);
        do_tick(1, 8'hFB, 7'b1111001, 1'b1, 0, 0);
        for (int k = 3; k < 8; k++) begin
            an_k = ~(8'b0000_0001 << k);
`ifdef SEG_LZB_EN
            do_tick(0, 8'hFF, 7'h7F, 1'b1, 0, 0);
`else
            do_tick(1, an_k, 7'b1000000, 1'b1, 0, 0);
`endif
        end

        // Drain: every expectation must have been consumed
        repeat (20) @(negedge clk_in);
        check("digit_queue_left", 64'(exp_q.size()), 64'd0);
        check("ack_queue_left", 64'(ack_q.size()), 64'd0);
        check("fs_queue_left", 64'(fs_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
